sram_seq_ctrl: RTL
==================

// Module: sram_seq_ctrl
// PURPOSE
// - Sequencer in front of the 8-bank coefficient sram used by the FIR filter.
// - LOAD phase: streams BLKS*DEPTH coefficient words into the sram through the
//   write port (CADDR/D), one word per accepted handshake.
// - RUN phase: forwards 8-lane read address vectors to A7..A0 and flags when
//   Q7..Q0 are valid. Prevents reads of a partially loaded table.
// PARAMETERS
// - BLKS   8    number of sram banks (CADDR[10:8] selects the bank)
// - DEPTH  256  words per bank
// - DW     20   coefficient word width
// - AW     8    per-bank address width; CADDR width = AW+3
// PORTS
// - clk         in   1     clock; all state updates on posedge
// - rst_n       in   1     synchronous, active-low reset
// - load_start  in   1     1-cycle pulse: begin (re)loading the table
// - wr_valid    in   1     wr_data carries a valid coefficient
// - wr_ready    out  1     controller accepts wr_data this cycle
// - wr_data     in   DW    coefficient word, written in address order
// - load_done   out  1     1-cycle pulse after the last word is written
// - loaded      out  1     table complete; sticky until next load_start/reset
// - rd_valid    in   1     rd_addr carries a valid 8-lane read request
// - rd_ready    out  1     controller accepts rd_addr this cycle
// - rd_addr     in   8*AW  lane i = rd_addr[i*AW +: AW], i=0..7
// - q_valid     out  1     sram Q7..Q0 hold the data for the last accepted read
// - CEN         out  1     sram chip enable, active low
// - WEN         out  1     sram write enable, active low
// - CADDR       out  AW+3  sram write address {bank, word}
// - D           out  DW    sram write data
// - A           out  8*AW  sram read addresses, lane i drives Ai
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, wcnt=0. Outputs: CEN=1, WEN=1,
//   CADDR=0, D=0, A=0, load_done=0, loaded=0, q_valid=0.
// - FSM states: IDLE, LOAD, RUN.
//   - IDLE --load_start--> LOAD.
//   - LOAD --last word accepted--> RUN.
//   - RUN --load_start--> LOAD.
//   - load_start while in LOAD is ignored; no restart.
// - wr_ready = (state==LOAD). rd_ready = (state==RUN) & ~load_start.
//   Both are combinational.
// - Entering LOAD: wcnt=0, loaded=0.
// - Write accept (wr_valid & wr_ready): registered at the next posedge to
//   CEN=0, WEN=0, CADDR=wcnt, D=wr_data; wcnt increments.
// - Gap cycles in LOAD (wr_valid=0): CEN=1, WEN=1, wcnt holds.
// - Last word is wcnt == BLKS*DEPTH-1. After it is accepted, the next cycle
//   has load_done=1 and loaded=1, and state becomes RUN.
// - wcnt never wraps; width is AW+3 bits and the counter stops in RUN.
// - Read accept (rd_valid & rd_ready): registered to CEN=0, WEN=1, A=rd_addr.
//   q_valid=1 one cycle after the sram cycle (2 posedges after accept).
//   Back-to-back reads are allowed at 1 per cycle, fully pipelined.
// - No access in a cycle: CEN=1, WEN=1, D=0; A and CADDR hold their last value.
// - rd_valid in IDLE or LOAD is stalled (rd_ready=0), never dropped or errored.
// - load_start and rd_valid in the same RUN cycle: load_start wins, the read
//   is not accepted, and a read already in flight still produces its q_valid.
// - Reset mid-LOAD: loaded=0, and the table must be reloaded from word 0.
// - Reset mid-RUN: any pending q_valid is cancelled.
// TESTING
// - Reset then idle 5 cycles -> CEN=WEN=1, loaded=0, wr_ready=rd_ready=0.
// - load_start, then 2048 words with wr_valid=1 every cycle -> write k has
//   CADDR=k, D=word k. load_done pulses once, 1 cycle after word 2047.
//   Model-based readback of all 2048 addresses matches.
// - Load with wr_valid=0 on every 3rd cycle -> CADDR sequence has no gaps or
//   duplicates; CEN=1 in every gap cycle.
// - RUN: 256 back-to-back reads with random lanes -> q_valid on exactly 256
//   cycles, 2 cycles after each accept; Q7..Q0 match the loaded model.
// - rd_valid held during LOAD -> rd_ready=0 until loaded=1. The first read is
//   accepted in the cycle RUN is entered.
// - Reset after word 1000 of a load -> loaded=0. A new load_start restarts at
//   CADDR=0. Also: load_start together with rd_valid in RUN -> read not
//   accepted, state=LOAD.

Source files
------------

// File: rtl/sram_seq_ctrl_if.sv
// Bus bundle between the FIR coefficient sequencer and its users: load/write
// handshake, read handshake and the 8-bank sram port.
interface sram_seq_ctrl_if #(
    parameter int DW = 20,
    parameter int AW = 8
) ();
    // Handshakes: a transfer happens in every cycle where valid and ready are
    // both high at the posedge; valid may rise freely, ready never waits on valid.
    logic              load_start;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic              load_done;
    logic              loaded;
    logic              rd_valid;
    logic              rd_ready;
    logic [8*AW-1:0]   rd_addr;
    logic              q_valid;
    logic              CEN;
    logic              WEN;
    logic [AW+2:0]     CADDR;
    logic [DW-1:0]     D;
    logic [8*AW-1:0]   A;

    modport slave (
        input  load_start, wr_valid, wr_data, rd_valid, rd_addr,
        output wr_ready, load_done, loaded, rd_ready, q_valid,
        output CEN, WEN, CADDR, D, A
    );

    modport master (
        output load_start, wr_valid, wr_data, rd_valid, rd_addr,
        input  wr_ready, load_done, loaded, rd_ready, q_valid,
        input  CEN, WEN, CADDR, D, A
    );
endinterface

// File: rtl/sram_seq_ctrl.sv
// Sequencer for the 8-bank FIR coefficient sram: loads the full table through
// the write port, then forwards pipelined 8-lane reads once the table is complete.
module sram_seq_ctrl #(
    parameter int BLKS  = 8,
    parameter int DEPTH = 256,
    parameter int DW    = 20,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_seq_ctrl_if.slave     bus,
    output logic [1:0]         o_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam int            TOTAL  = BLKS * DEPTH;
    localparam logic [AW+2:0] W_LAST = (AW+3)'(TOTAL - 1);

    logic [1:0]      r_state;
    logic [AW+2:0]   r_wcnt;
    logic            r_loaded;
    logic            r_load_done;
    logic            r_cen;
    logic            r_wen;
    logic [AW+2:0]   r_caddr;
    logic [DW-1:0]   r_d;
    logic [8*AW-1:0] r_a;
    logic            r_rd_pipe;
    logic            r_q_valid;

    logic w_wr_ready;
    logic w_rd_ready;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_last;

    // load_start has priority over a read offered in the same RUN cycle.
    assign w_wr_ready = (r_state == S_LOAD);
    assign w_rd_ready = (r_state == S_RUN) && !bus.load_start;
    assign w_wr_acc   = bus.wr_valid && w_wr_ready;
    assign w_rd_acc   = bus.rd_valid && w_rd_ready;
    assign w_last     = (r_wcnt == W_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_loaded    <= 1'b0;
            r_load_done <= 1'b0;
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_caddr     <= '0;
            r_d         <= '0;
            r_a         <= '0;
            r_rd_pipe   <= 1'b0;
            r_q_valid   <= 1'b0;
        end else begin
            r_cen       <= 1'b1;
            r_wen       <= 1'b1;
            r_d         <= '0;
            r_load_done <= 1'b0;
            // Read data is valid one cycle after the sram cycle; the pipe keeps
            // running across a load_start so in-flight reads still complete.
            r_rd_pipe   <= w_rd_acc;
            r_q_valid   <= r_rd_pipe;

            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state  <= S_LOAD;
                        r_wcnt   <= '0;
                        r_loaded <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_wr_acc) begin
                        r_cen   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_caddr <= r_wcnt;
                        r_d     <= bus.wr_data;
                        // Counter parks on the last address instead of wrapping.
                        if (w_last) begin
                            r_state     <= S_RUN;
                            r_load_done <= 1'b1;
                            r_loaded    <= 1'b1;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.load_start) begin
                        r_state  <= S_LOAD;
                        r_wcnt   <= '0;
                        r_loaded <= 1'b0;
                    end else if (w_rd_acc) begin
                        r_cen <= 1'b0;
                        r_a   <= bus.rd_addr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.rd_ready  = w_rd_ready;
    assign bus.load_done = r_load_done;
    assign bus.loaded    = r_loaded;
    assign bus.q_valid   = r_q_valid;
    assign bus.CEN       = r_cen;
    assign bus.WEN       = r_wen;
    assign bus.CADDR     = r_caddr;
    assign bus.D         = r_d;
    assign bus.A         = r_a;
    assign o_state       = r_state;
endmodule
